// File: rtl/pcie_txeq_coef_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pcie_txeq_coef_search
// Description : Gen3 TX equalisation coefficient sweeper. Walks a programmable
//               table of pre/post-cursor pairs and skips entries that break the
//               FS/LF rules. Each legal pair is applied, allowed to settle, and
//               then scored with a figure of merit (FOM) requested from the core.
//               The index and FOM of the best entry are reported.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_txeq_coef_search #(
  parameter int N_COEF      = 11,
  parameter int COEF_W      = 6,
  parameter int FOM_W       = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [3:0]        tbl_addr,
  input  logic [COEF_W-1:0] tbl_pre,
  input  logic [COEF_W-1:0] tbl_post,
  input  logic              tbl_en,
  input  logic [COEF_W-1:0] fs,
  input  logic [COEF_W-1:0] lf,
  input  logic              start,
  output logic              coef_valid,
  output logic [COEF_W-1:0] coef_pre,
  output logic [COEF_W-1:0] coef_post,
  output logic              fom_req,
  input  logic              fom_valid,
  input  logic [FOM_W-1:0]  fom,
  output logic              busy,
  output logic              done,
  output logic [3:0]        best_idx,
  output logic [FOM_W-1:0]  best_fom,
  output logic              found,
  output logic [3:0]        timeout_cnt
);

  // Three extra bits keep fs - 2*(pre+post) exact and signed.
  localparam int CHK_W = COEF_W + 3;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SET_W-1:0] SETTLE_LOAD  = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TIMEOUT_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       LAST_IDX     = 4'(N_COEF - 1);
  localparam logic [4:0]       N_LIM        = 5'(N_COEF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_EVAL   = 3'd4,
    S_NEXT   = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Coefficient table
  logic [COEF_W-1:0] r_tbl_pre  [N_COEF];
  logic [COEF_W-1:0] r_tbl_post [N_COEF];
  logic              r_tbl_en   [N_COEF];

  // Sweep context
  logic [COEF_W-1:0] r_fs;
  logic [COEF_W-1:0] r_lf;
  logic [3:0]        r_idx;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;

  // Registered outputs
  logic              r_coef_valid;
  logic [COEF_W-1:0] r_coef_pre;
  logic [COEF_W-1:0] r_coef_post;
  logic              r_fom_req;
  logic [3:0]        r_best_idx;
  logic [FOM_W-1:0]  r_best_fom;
  logic              r_found;
  logic [3:0]        r_timeout_cnt;

  // Combinational helpers
  logic                     w_tbl_wr;
  logic [COEF_W-1:0]        w_ent_pre;
  logic [COEF_W-1:0]        w_ent_post;
  logic                     w_ent_en;
  logic [CHK_W-1:0]         w_sum;
  logic signed [CHK_W-1:0]  w_margin;
  logic signed [CHK_W-1:0]  w_lf_ext;
  logic                     w_legal;
  logic                     w_settle_zero;
  logic                     w_tmo_zero;
  logic                     w_better;

  // The table is frozen while a sweep runs, and out-of-range writes are dropped.
  assign w_tbl_wr = tbl_we && (r_state == S_IDLE) && ({1'b0, tbl_addr} < N_LIM);

  assign w_ent_pre  = r_tbl_pre[r_idx];
  assign w_ent_post = r_tbl_post[r_idx];
  assign w_ent_en   = r_tbl_en[r_idx];

  // Legality: entry enabled, pre <= fs/4, and fs - 2*(pre+post) >= lf.
  assign w_sum    = CHK_W'(w_ent_pre) + CHK_W'(w_ent_post);
  assign w_margin = $signed(CHK_W'(r_fs)) - $signed({w_sum[CHK_W-2:0], 1'b0});
  assign w_lf_ext = $signed(CHK_W'(r_lf));
  assign w_legal  = w_ent_en && (w_ent_pre <= (r_fs >> 2)) && (w_margin >= w_lf_ext);

  assign w_settle_zero = (r_settle_cnt == '0);
  assign w_tmo_zero    = (r_tmo_cnt == '0);
  // The first success always wins. After that, a strictly larger FOM is needed,
  // so a tie keeps the lower index.
  assign w_better      = !r_found || (fom > r_best_fom);

  assign coef_valid  = r_coef_valid;
  assign coef_pre    = r_coef_pre;
  assign coef_post   = r_coef_post;
  assign fom_req     = r_fom_req;
  assign best_idx    = r_best_idx;
  assign best_fom    = r_best_fom;
  assign found       = r_found;
  assign timeout_cnt = r_timeout_cnt;

  // Table storage: written from the control plane, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_COEF; i++) begin
        r_tbl_pre[i]  <= '0;
        r_tbl_post[i] <= '0;
        r_tbl_en[i]   <= 1'b0;
      end
    end else if (w_tbl_wr) begin
      r_tbl_pre[tbl_addr]  <= tbl_pre;
      r_tbl_post[tbl_addr] <= tbl_post;
      r_tbl_en[tbl_addr]   <= tbl_en;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, plus busy/done decoded from the state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        busy        = 1'b1;
        w_state_nxt = w_legal ? S_APPLY : S_NEXT;
      end
      S_APPLY: begin
        busy        = 1'b1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (w_settle_zero) begin
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        busy = 1'b1;
        if (fom_valid || w_tmo_zero) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        busy        = 1'b1;
        w_state_nxt = (r_idx == LAST_IDX) ? S_FIN : S_CHECK;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sweep datapath: coefficient presentation, counters and best tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fs          <= '0;
      r_lf          <= '0;
      r_idx         <= '0;
      r_settle_cnt  <= '0;
      r_tmo_cnt     <= '0;
      r_coef_valid  <= 1'b0;
      r_coef_pre    <= '0;
      r_coef_post   <= '0;
      r_fom_req     <= 1'b0;
      r_best_idx    <= '0;
      r_best_fom    <= '0;
      r_found       <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fs          <= fs;
            r_lf          <= lf;
            r_idx         <= '0;
            r_best_idx    <= '0;
            r_best_fom    <= '0;
            r_found       <= 1'b0;
            r_timeout_cnt <= '0;
          end
        end
        S_APPLY: begin
          r_coef_pre   <= w_ent_pre;
          r_coef_post  <= w_ent_post;
          r_coef_valid <= 1'b1;
          r_settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (w_settle_zero) begin
            r_fom_req <= 1'b1;
            r_tmo_cnt <= TIMEOUT_LOAD;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        S_EVAL: begin
          // A response on the final timeout cycle still counts as valid.
          if (fom_valid) begin
            r_fom_req <= 1'b0;
            r_found   <= 1'b1;
            if (w_better) begin
              r_best_idx <= r_idx;
              r_best_fom <= fom;
            end
          end else if (w_tmo_zero) begin
            r_fom_req <= 1'b0;
            if (r_timeout_cnt != 4'hF) begin
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
          end
        end
        S_NEXT: begin
          r_coef_valid <= 1'b0;
          if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_txeq_coef_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pcie_txeq_coef_search
// Description : Self-checking bench for pcie_txeq_coef_search. Uses a vector
//               table of single-entry sweeps plus hand-written multi-entry,
//               timeout and reset sequences. Expected sweep results are
//               queued at start and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_txeq_coef_search;

  localparam int N_COEF      = 11;
  localparam int COEF_W      = 6;
  localparam int FOM_W       = 8;
  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 255;
  localparam int LEGAL_CYC   = SETTLE_CYC + 4;
  localparam int SKIP_CYC    = 2;

  logic              clk;
  logic              rst;
  logic              tbl_we;
  logic [3:0]        tbl_addr;
  logic [COEF_W-1:0] tbl_pre;
  logic [COEF_W-1:0] tbl_post;
  logic              tbl_en;
  logic [COEF_W-1:0] fs;
  logic [COEF_W-1:0] lf;
  logic              start;
  logic              coef_valid;
  logic [COEF_W-1:0] coef_pre;
  logic [COEF_W-1:0] coef_post;
  logic              fom_req;
  logic              fom_valid;
  logic [FOM_W-1:0]  fom;
  logic              busy;
  logic              done;
  logic [3:0]        best_idx;
  logic [FOM_W-1:0]  best_fom;
  logic              found;
  logic [3:0]        timeout_cnt;

  pcie_txeq_coef_search #(
    .N_COEF     (N_COEF),
    .COEF_W     (COEF_W),
    .FOM_W      (FOM_W),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_pre    (tbl_pre),
    .tbl_post   (tbl_post),
    .tbl_en     (tbl_en),
    .fs         (fs),
    .lf         (lf),
    .start      (start),
    .coef_valid (coef_valid),
    .coef_pre   (coef_pre),
    .coef_post  (coef_post),
    .fom_req    (fom_req),
    .fom_valid  (fom_valid),
    .fom        (fom),
    .busy       (busy),
    .done       (done),
    .best_idx   (best_idx),
    .best_fom   (best_fom),
    .found      (found),
    .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int idx; int fom; int found; int tcnt; int busy_cyc; int reqs;
  } exp_t;

  typedef struct {
    int addr; int pre; int post; int en; int fs; int lf; int fomv;
    int exp_found; int exp_idx; int exp_fom; int exp_reqs; int exp_busy;
  } vec_t;

  exp_t exp_q[$];
  int   fom_q[$];

  // Monitor state
  int busy_cyc    = 0;
  int req_cnt     = 0;
  int req_len     = 0;
  int req_len_max = 0;
  int cv_len      = 0;
  int cv_len_last = 0;
  int cv_pre      = 0;
  int cv_post     = 0;
  int done_cnt    = 0;
  bit prev_req    = 1'b0;
  bit prev_cv     = 1'b0;
  exp_t mon_e;

  // Scoreboard/monitor: tracks activity and compares the result on each done.
  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (fom_req) begin
        if (!prev_req) begin
          req_cnt++;
          req_len = 0;
        end
        req_len++;
        if (req_len > req_len_max) req_len_max = req_len;
      end
      if (coef_valid) begin
        if (!prev_cv) cv_len = 0;
        cv_len++;
        cv_pre  = int'(coef_pre);
        cv_post = int'(coef_post);
      end else if (prev_cv) begin
        cv_len_last = cv_len;
      end
      prev_req = fom_req;
      prev_cv  = coef_valid;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("best_idx",    int'(best_idx),    mon_e.idx);
          check("best_fom",    int'(best_fom),    mon_e.fom);
          check("found",       int'(found),       mon_e.found);
          check("timeout_cnt", int'(timeout_cnt), mon_e.tcnt);
          check("busy_cycles", busy_cyc,          mon_e.busy_cyc);
          check("fom_req_cnt", req_cnt,           mon_e.reqs);
        end
        busy_cyc = 0;
        req_cnt  = 0;
      end
    end
  end

  // FOM responder: answers each request on the first cycle, or withholds on -1.
  int  resp_v;
  bit  episode = 1'b0;
  initial begin
    fom_valid = 1'b0;
    fom       = '0;
    forever begin
      @(negedge clk);
      fom_valid = 1'b0;
      if (fom_req && !episode) begin
        episode = 1'b1;
        if (fom_q.size() > 0) begin
          resp_v = fom_q.pop_front();
          if (resp_v >= 0) begin
            fom_valid = 1'b1;
            fom       = resp_v[FOM_W-1:0];
          end
        end
      end else if (!fom_req) begin
        episode = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    busy_cyc    = 0;
    req_cnt     = 0;
    req_len_max = 0;
    cv_len_last = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fom_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic write_entry(input int addr, input int pre, input int post, input int en);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = 4'(addr);
    tbl_pre  = COEF_W'(pre);
    tbl_post = COEF_W'(post);
    tbl_en   = (en != 0);
    @(negedge clk);
    tbl_we   = 1'b0;
  endtask

  task automatic run_sweep(input int fs_v, input int lf_v, input exp_t e);
    @(negedge clk);
    fs    = COEF_W'(fs_v);
    lf    = COEF_W'(lf_v);
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("sweep_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  vec_t vecs[10];
  vec_t v;
  exp_t e;
  int   dc;
  int   n;

  initial begin
    // Single-entry sweeps: {addr,pre,post,en,fs,lf,fom, found,idx,fom,reqs,busy}
    vecs[0] = '{5, 0, 0, 1, 24, 8,   7, 1,  5,   7, 1, LEGAL_CYC + (N_COEF-1)*SKIP_CYC};
    vecs[1] = '{3, 7, 0, 1, 24, 8,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};
    vecs[2] = '{2, 4, 5, 1, 24, 8,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};
    vecs[3] = '{0, 6, 0, 1, 24, 8,  33, 1,  0,  33, 1, LEGAL_CYC + (N_COEF-1)*SKIP_CYC};
    vecs[4] = '{10,2, 6, 1, 24, 8,   0, 1, 10,   0, 1, LEGAL_CYC + (N_COEF-1)*SKIP_CYC};
    vecs[5] = '{7, 2, 7, 1, 24, 8,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};
    vecs[6] = '{4, 0, 0, 0, 24, 8,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};
    vecs[7] = '{1, 0, 3, 1,  8, 2, 200, 1,  1, 200, 1, LEGAL_CYC + (N_COEF-1)*SKIP_CYC};
    vecs[8] = '{9, 3, 0, 1,  8, 0,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};
    vecs[9] = '{6, 0, 5, 1,  8, 0,  50, 0,  0,   0, 0, N_COEF*SKIP_CYC};

    rst      = 1'b1;
    tbl_we   = 1'b0;
    tbl_addr = '0;
    tbl_pre  = '0;
    tbl_post = '0;
    tbl_en   = 1'b0;
    fs       = '0;
    lf       = '0;
    start    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",        int'(busy),        0);
    check("rst_done",        int'(done),        0);
    check("rst_coef_valid",  int'(coef_valid),  0);
    check("rst_coef",        int'({coef_pre, coef_post}), 0);
    check("rst_fom_req",     int'(fom_req),     0);
    check("rst_best",        int'({best_idx, best_fom}), 0);
    check("rst_found",       int'(found),       0);
    check("rst_timeout_cnt", int'(timeout_cnt), 0);
    rst = 1'b0;

    // Vector table: legality rules, boundaries and single-entry latency.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      do_reset();
      write_entry(v.addr, v.pre, v.post, v.en);
      fom_q.push_back(v.fomv);
      e = '{v.exp_idx, v.exp_fom, v.exp_found, 0, v.exp_busy, v.exp_reqs};
      run_sweep(v.fs, v.lf, e);
      wait_done(400);
      if (v.exp_reqs != 0) begin
        check("coef_valid_len", cv_len_last, SETTLE_CYC + 2);
        check("coef_pre_seen",  cv_pre,      v.pre);
        check("coef_post_seen", cv_post,     v.post);
      end
    end

    // Four legal entries with a FOM tie; ignored writes and start while busy.
    do_reset();
    write_entry(12, 1, 1, 1);
    write_entry(0, 2, 4, 1);
    write_entry(1, 0, 6, 1);
    write_entry(2, 3, 3, 1);
    write_entry(3, 4, 0, 1);
    fom_q.push_back(10); fom_q.push_back(40); fom_q.push_back(40); fom_q.push_back(20);
    dc = done_cnt;
    e = '{1, 40, 1, 0, 4*LEGAL_CYC + (N_COEF-4)*SKIP_CYC, 4};
    run_sweep(24, 8, e);
    repeat (25) @(negedge clk);
    write_entry(6, 0, 0, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    repeat (5) @(negedge clk);
    check("done_pulses", done_cnt - dc, 1);
    check("busy_after_done", int'(busy), 0);

    // Same table again: entry 6 and address 12 must not have been written.
    fom_q.push_back(10); fom_q.push_back(40); fom_q.push_back(40); fom_q.push_back(20);
    run_sweep(24, 8, e);
    wait_done(2000);

    // Withheld response on entry 2.
    do_reset();
    write_entry(0, 2, 4, 1);
    write_entry(1, 0, 6, 1);
    write_entry(2, 3, 3, 1);
    write_entry(3, 4, 0, 1);
    fom_q.push_back(10); fom_q.push_back(40); fom_q.push_back(-1); fom_q.push_back(20);
    e = '{1, 40, 1, 1,
          3*LEGAL_CYC + (SETTLE_CYC + 3 + TIMEOUT_CYC) + (N_COEF-4)*SKIP_CYC, 4};
    run_sweep(24, 8, e);
    wait_done(3000);
    check("fom_req_hold", req_len_max, TIMEOUT_CYC);

    // Reset during SETTLE of entry 4: no done pulse, and the table is cleared.
    do_reset();
    for (int a = 0; a < 6; a++) write_entry(a, 1, 1, 1);
    for (int a = 0; a < 6; a++) fom_q.push_back(5 + a);
    @(negedge clk);
    fs    = 6'd24;
    lf    = 6'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (req_cnt < 4 && n < 500) begin @(negedge clk); n++; end
    while (coef_valid && n < 600) begin @(negedge clk); n++; end
    while (!coef_valid && n < 700) begin @(negedge clk); n++; end
    check("reached_entry4", int'(coef_valid && !fom_req && found), 1);
    repeat (3) @(negedge clk);
    #2;
    dc  = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",       int'(busy),       0);
    check("mid_rst_coef_valid", int'(coef_valid), 0);
    check("mid_rst_found",      int'(found),      0);
    check("mid_rst_best_fom",   int'(best_fom),   0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", done_cnt - dc, 0);
    fom_q.delete();
    @(posedge clk);
    #1;
    clear_mon();
    e = '{0, 0, 0, 0, N_COEF*SKIP_CYC, 0};
    run_sweep(24, 8, e);
    wait_done(400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcie_txeq_coef_search.md
Name: pcie_txeq_coef_search

Overview:
- Soft-logic Gen3 TX equalisation coefficient sweeper for the LIFCL PCIE_CORE fabric interface.
- Holds a programmable table of N_COEF pre/post-cursor pairs, the generalised form of the fixed COEFn_PRE/COEFn_POST core settings.
- Walks the enabled entries, skipping those that break the FS/LF rules. For each entry it presents the pair to the link, waits a settle time, requests a figure of merit (FOM), and reports the index and value of the best entry.
- Sits between the fabric control plane and the PCIE_CORE equalisation request/FOM interface.

Parameters:
- N_COEF, 11, number of table entries (2..16).
- COEF_W, 6, width of the pre, post, FS and LF values.
- FOM_W, 8, width of the FOM value.
- SETTLE_CYC, 16, cycles to wait after applying a pair (>=1).
- TIMEOUT_CYC, 255, maximum cycles to wait for fom_valid (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  4  table index.
- tbl_pre  in  COEF_W  pre-cursor value to write.
- tbl_post  in  COEF_W  post-cursor value to write.
- tbl_en  in  1  entry enable bit to write.
- fs  in  COEF_W  full-swing value; sampled at start.
- lf  in  COEF_W  low-frequency limit; sampled at start.
- start  in  1  begin a sweep (pulse).
- coef_valid  out  1  coefficient pair presented to the core.
- coef_pre  out  COEF_W  pre-cursor under evaluation.
- coef_post  out  COEF_W  post-cursor under evaluation.
- fom_req  out  1  FOM request, level held until response or timeout.
- fom_valid  in  1  FOM response strobe.
- fom  in  FOM_W  FOM value, qualified by fom_valid.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- best_idx  out  4  index of the best entry.
- best_fom  out  FOM_W  FOM of the best entry.
- found  out  1  at least one entry was evaluated successfully.
- timeout_cnt  out  4  entries that timed out, saturating at 15.

Behaviour:
- Reset values: all outputs 0; state IDLE. Table contents are cleared to pre=0, post=0, en=0.
- Table writes:
  - Accepted only in IDLE when tbl_addr < N_COEF; other writes are ignored.
  - A write in the same cycle as start takes effect before the sweep reads the table.
- FSM states: IDLE, CHECK, APPLY, SETTLE, EVAL, NEXT, FIN.
- IDLE:
  - On start: latch fs and lf; clear best_fom, best_idx, found and timeout_cnt; idx=0; busy=1; go to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle): the entry is legal when all of the following hold.
  - en=1.
  - pre <= fs>>2.
  - fs - 2*(pre+post) >= lf, computed signed at COEF_W+3 bits.
  - Legal -> APPLY; illegal -> NEXT.
- APPLY (1 cycle): drive coef_pre and coef_post, set coef_valid=1, load the settle counter with SETTLE_CYC-1, go to SETTLE.
- SETTLE: count down; when the count reaches 0, assert fom_req, load the timeout counter with TIMEOUT_CYC-1, go to EVAL.
- EVAL:
  - fom_valid=1: drop fom_req.
    - Update best when fom > best_fom, or when found=0 (first success).
    - Ties keep the lower index.
    - Set found=1, go to NEXT.
  - Timeout counter reaches 0 with no fom_valid: drop fom_req, increment timeout_cnt (saturating), go to NEXT.
  - fom_valid in the same cycle the counter reaches 0 counts as a valid response.
  - fom_valid outside EVAL is ignored.
- NEXT (1 cycle): coef_valid=0. If idx == N_COEF-1 go to FIN, otherwise idx+1 and go to CHECK.
- FIN (1 cycle): done=1, busy=0, go to IDLE.
- best_idx, best_fom, found and timeout_cnt hold their values until the next start.
- Latency, all entries legal with immediate fom_valid: per entry 1 (CHECK) + 1 (APPLY) + SETTLE_CYC + 1 (EVAL) + 1 (NEXT); plus 1 cycle for FIN.
- An illegal entry costs 2 cycles (CHECK + NEXT).
- Reset mid-sweep returns all state and the table to reset values immediately. No done pulse is produced.

Test Plan:
- Sweep with entries 0..3 enabled as (pre,post) = (2,4),(0,6),(3,3),(4,0); fs=24, lf=8; FOM responses 10, 40, 40, 20 -> best_idx=1, best_fom=40 (tie keeps the lower index), found=1, timeout_cnt=0, done pulses once.
- Entry 5 with pre=0, post=0, en=1 and all other entries disabled; FOM response 7 -> best_idx=5, best_fom=7. coef_pre=0 and coef_post=0 seen with coef_valid=1 for exactly SETTLE_CYC+2 cycles.
- Illegal entries: pre=7 with fs=24 (7 > 6), and pre+post=9 with fs=24, lf=8 (24-18 < 8) -> fom_req never asserts for those entries; found=0 if they are the only enabled entries.
- fom_valid withheld on entry 2 -> fom_req held for TIMEOUT_CYC cycles, then dropped; timeout_cnt=1; sweep continues to entry 3.
- rst asserted in SETTLE of entry 4 -> busy=0, coef_valid=0, table cleared, no done pulse; a new sweep after rst finds found=0.
- Table write to address 12 with N_COEF=11, and a write while busy -> no table change; start pulse while busy -> no restart, total sweep cycle count unchanged.
